// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 keyboard transmitter.
// Queues scan-code bytes in a small FIFO and serialises each one as an
// 11-bit PS/2 frame (start, 8 data LSB first, odd parity, stop) with an
// idle gap after the stop bit. All outputs come straight from flops.
module ps2_kbd_tx #(
    parameter int CLK_DIV    = 2000,
    parameter int FIFO_AW    = 4,
    parameter int GAP_HALVES = 2
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [7:0] din,
    input  logic       wr,
    input  logic       inhibit,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int GAP_CYC = GAP_HALVES * CLK_DIV;
    localparam int TMAX    = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
    localparam int TW      = $clog2(TMAX + 1);
    localparam int CW      = FIFO_AW + 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, GAP} state_t;

    state_t              state, state_d;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]       count, count_d;
    logic                push, pop;
    logic [7:0]          head;
    logic [TW-1:0]       timer, timer_d;
    logic [3:0]          bit_cnt, bit_cnt_d;
    logic [10:0]         shreg, shreg_d;
    logic                inhibit_q;
    logic                busy_d, ps2_clk_d, ps2_data_d;

    // full is the registered flag, so a write while full is dropped even if
    // the FSM pops in the same cycle
    assign push = wr & ~full;
    assign pop  = (state == LOAD) & ~empty;
    assign head = mem[rd_ptr];

    // FIFO occupancy after this edge
    always_comb begin
        count_d = count;
        if (push && !pop)
            count_d = count + CW'(1);
        else if (!push && pop)
            count_d = count - CW'(1);
    end

    // FIFO storage; contents need no reset, pointers and count guard them
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    // FIFO pointers, count and registered status flags
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            count    <= count_d;
            full     <= (count_d == CW'(DEPTH));
            empty    <= (count_d == '0);
            overflow <= wr & full;
        end
    end

    // Frame sequencer next state; outputs are derived from the next state so
    // they can be registered without adding a cycle of latency
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        unique case (state)
            IDLE: begin
                if (!empty && !inhibit_q)
                    state_d = LOAD;
            end
            LOAD: begin
                shreg_d   = {1'b1, ~^head, head, 1'b0};
                bit_cnt_d = '0;
                timer_d   = '0;
                state_d   = HIGH;
            end
            HIGH: begin
                if (timer == HALF_LAST) begin
                    timer_d = '0;
                    state_d = LOW;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            LOW: begin
                if (timer == HALF_LAST) begin
                    timer_d = '0;
                    shreg_d = {1'b1, shreg[10:1]};
                    if (bit_cnt < 4'd10) begin
                        bit_cnt_d = bit_cnt + 4'd1;
                        state_d   = HIGH;
                    end else begin
                        state_d = (GAP_CYC == 0) ? IDLE : GAP;
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        ps2_clk_d  = (state_d != LOW);
        ps2_data_d = (state_d == HIGH || state_d == LOW) ? shreg_d[0] : 1'b1;
    end

    // Sequencer state and registered PS/2 line drivers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '1;
            inhibit_q <= 1'b1;
            busy      <= 1'b0;
            ps2_clk   <= 1'b1;
            ps2_data  <= 1'b1;
        end else begin
            state     <= state_d;
            timer     <= timer_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            // inhibit is registered like empty, so releasing either one
            // starts the frame with the same two-cycle latency
            inhibit_q <= inhibit;
            busy      <= busy_d;
            ps2_clk   <= ps2_clk_d;
            ps2_data  <= ps2_data_d;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: directed writes push hand-computed
// frames into a scoreboard queue; a line monitor decodes PS/2 frames and
// compares them, while the stimulus process checks timing and flags.
module tb_ps2_kbd_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_AW    = 4;
    localparam int GAP_HALVES = 2;
    localparam int FRAME      = 2 + (22 + GAP_HALVES) * CLK_DIV;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr = 1'b0;
    logic       inhibit = 1'b0;
    logic       full, empty, busy, overflow, ps2_clk, ps2_data;

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW), .GAP_HALVES(GAP_HALVES)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .din      (din),
        .wr       (wr),
        .inhibit  (inhibit),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       p;
    } exp_t;
    exp_t exp_q[$];

    // Line monitor state
    int          nbits = 0, falls = 0, starts = 0, frames = 0;
    int          last_start = 0, prev_start = 0, last_fall = 0;
    logic        prev_clk = 1'b1, prev_data = 1'b1, low_changed = 1'b0;
    logic [10:0] frame_bits = '0;
    exp_t        e;

    always @(negedge clk) begin
        if (!n_reset) begin
            nbits = 0;
            prev_clk = 1'b1;
            prev_data = 1'b1;
            low_changed = 1'b0;
        end else begin
            if (prev_clk && ps2_clk && prev_data && !ps2_data && nbits == 0) begin
                prev_start = last_start;
                last_start = cyc;
                starts++;
            end
            if (!prev_clk && !ps2_clk && ps2_data !== prev_data)
                low_changed = 1'b1;
            if (!prev_clk && ps2_clk) begin
                check("data_stable_low", 32'(low_changed), 32'd0);
                low_changed = 1'b0;
            end
            if (prev_clk && !ps2_clk) begin
                falls++;
                if (nbits == 0)
                    check("first_fall_delay", cyc - last_start, CLK_DIV);
                else
                    check("fall_spacing", cyc - last_fall, 2 * CLK_DIV);
                last_fall = cyc;
                frame_bits[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    nbits = 0;
                    frames++;
                    check("sb_frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_bits", 32'(frame_bits), 32'({1'b1, e.p, e.b, 1'b0}));
                    end
                end
            end
            prev_clk = ps2_clk;
            prev_data = ps2_data;
        end
    end

    // Called at a negedge; returns at the next negedge with cyc == write edge
    task automatic wr_byte(input logic [7:0] b, input logic p, input logic expect_frame);
        exp_t x;
        wr = 1'b1;
        din = b;
        if (expect_frame) begin
            x.b = b;
            x.p = p;
            exp_q.push_back(x);
        end
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(busy == 1'b0 && empty == 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_busy_low(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_low_within_budget", 32'(n < budget), 32'd1);
    endtask

    logic [7:0] t3_b [16] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                              8'h0F, 8'h10, 8'h11, 8'h3C, 8'h55, 8'hAA, 8'h80, 8'h7E};
    logic       t3_p [16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int n, m, s0, f0, fl0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
        check("rst_ps2_data", 32'(ps2_data), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0x1C: latency, bit timing, busy length
        f0 = frames;
        wr_byte(8'h1C, 1'b0, 1'b1);
        n = cyc;
        check("t1_empty_after_wr", 32'(empty), 32'd0);
        check("t1_data_idle_at_N", 32'(ps2_data), 32'd1);
        @(negedge clk);
        check("t1_busy_at_load", 32'(busy), 32'd1);
        check("t1_data_idle_at_load", 32'(ps2_data), 32'd1);
        @(negedge clk);
        check("t1_start_bit_at_N2", 32'(ps2_data), 32'd0);
        wait_cyc(n + 97);
        check("t1_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_busy_end", 32'(busy), 32'd0);
        wait_idle(50);
        check("t1_start_cycle", last_start - n, 2);
        check("t1_frames", frames - f0, 1);

        // Back-to-back 0xF0, 0x1C
        repeat (5) @(negedge clk);
        f0 = frames;
        wr_byte(8'hF0, 1'b1, 1'b1);
        n = cyc;
        wr_byte(8'h1C, 1'b0, 1'b1);
        wait_idle(2 * FRAME + 40);
        check("t2_first_start", prev_start - n, 2);
        check("t2_start_spacing", last_start - prev_start, FRAME);
        check("t2_frames", frames - f0, 2);

        // Fill FIFO while inhibited, overflow on 17th write, then drain
        repeat (5) @(negedge clk);
        inhibit = 1'b1;
        @(negedge clk);
        s0 = starts;
        f0 = frames;
        for (int i = 0; i < 16; i++) begin
            wr_byte(t3_b[i], t3_p[i], 1'b1);
            if (i == 14) check("t3_not_full_15", 32'(full), 32'd0);
        end
        check("t3_full_16", 32'(full), 32'd1);
        check("t3_no_overflow_yet", 32'(overflow), 32'd0);
        wr_byte(8'h99, 1'b0, 1'b0);
        check("t3_overflow_pulse", 32'(overflow), 32'd1);
        @(negedge clk);
        check("t3_overflow_one_cycle", 32'(overflow), 32'd0);
        check("t3_still_full", 32'(full), 32'd1);
        repeat (20) @(negedge clk);
        check("t3_held_busy", 32'(busy), 32'd0);
        check("t3_no_start", starts - s0, 0);
        inhibit = 1'b0;
        @(negedge clk);
        wait_idle(16 * FRAME + 60);
        check("t3_frames", frames - f0, 16);
        check("t3_queue_drained", exp_q.size(), 0);
        check("t3_empty", 32'(empty), 32'd1);

        // Inhibit mid-frame
        repeat (5) @(negedge clk);
        s0 = starts;
        f0 = frames;
        wr_byte(8'h5A, 1'b1, 1'b1);
        wr_byte(8'h21, 1'b1, 1'b1);
        repeat (30) @(negedge clk);
        inhibit = 1'b1;
        wait_busy_low(FRAME + 20);
        repeat (40) @(negedge clk);
        check("t4_held_busy", 32'(busy), 32'd0);
        check("t4_one_start", starts - s0, 1);
        check("t4_one_frame", frames - f0, 1);
        check("t4_pending", 32'(empty), 32'd0);
        inhibit = 1'b0;
        m = cyc + 1;
        @(negedge clk);
        wait_idle(FRAME + 40);
        check("t4_release_start", last_start - m, 2);
        check("t4_frames", frames - f0, 2);

        // Reset during bit 5 of a frame carrying 0x0F
        repeat (5) @(negedge clk);
        f0 = frames;
        s0 = starts;
        wr_byte(8'h0F, 1'b1, 1'b0);
        n = cyc;
        wait_cyc(n + 48);
        check("t5_clk_low_bit5", 32'(ps2_clk), 32'd0);
        check("t5_data_bit5", 32'(ps2_data), 32'd0);
        #2 n_reset = 1'b0;
        #1;
        check("t5_rst_clk", 32'(ps2_clk), 32'd1);
        check("t5_rst_data", 32'(ps2_data), 32'd1);
        check("t5_rst_empty", 32'(empty), 32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        fl0 = falls;
        repeat (200) @(negedge clk);
        check("t5_no_falls", falls - fl0, 0);
        check("t5_no_frame", frames - f0, 0);
        check("t5_one_start", starts - s0, 1);
        check("t5_idle_data", 32'(ps2_data), 32'd1);
        check("t5_idle_busy", 32'(busy), 32'd0);

        // Parity edge cases 0x00 and 0xFF
        f0 = frames;
        wr_byte(8'h00, 1'b1, 1'b1);
        wr_byte(8'hFF, 1'b1, 1'b1);
        wait_idle(2 * FRAME + 40);
        check("t6_frames", frames - f0, 2);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cyc %0d)", cyc);
        $fatal(1);
    end

endmodule
